// File: rtl/seq_tx_101.sv
// seq_tx_101: serial frame transmitter sending a "101" preamble, a zero-stuffed MSB-first payload and zero guard bits.
module seq_tx_101 #(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              seq_out,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        crnt_state
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP_BITS + 1);
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        PRE1  = 3'b001,
        PRE0  = 3'b010,
        PRE2  = 3'b011,
        DATA  = 3'b100,
        STUFF = 3'b101,
        GAP   = 3'b110
    } state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [1:0]        hist_q, hist_d;
    logic              accept;
    assign frame_done = state_q == GAP && gap_cnt_q == GW'(1);
    assign data_ready = state_q == IDLE || frame_done;
    assign accept     = data_valid && data_ready;
    assign busy       = state_q != IDLE;
    assign crnt_state = state_q;
    assign seq_out    = (state_q == PRE1 || state_q == PRE2) ? 1'b1 :
                        (state_q == DATA) ? shift_q[DATA_W-1] : 1'b0;
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        hist_d    = hist_q;
        case (state_q)
            IDLE:  state_d = IDLE;
            PRE1:  state_d = PRE0;
            PRE0:  state_d = PRE2;
            PRE2: begin
                hist_d  = 2'b01;
                state_d = DATA;
            end
            DATA: begin
                hist_d    = {hist_q[0], shift_q[DATA_W-1]};
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q - BW'(1);
                // the last payload bit never needs a stuff: the guard zeros follow anyway
                if (bit_cnt_q == BW'(1)) begin
                    state_d   = GAP;
                    gap_cnt_d = GW'(GAP_BITS);
                end else begin
                    state_d = (hist_d == 2'b10) ? STUFF : DATA;
                end
            end
            STUFF: begin
                hist_d  = 2'b00;
                state_d = DATA;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GW'(1);
                state_d   = frame_done ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d   = PRE1;
            shift_d   = data_in;
            bit_cnt_d = BW'(DATA_W);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            hist_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            hist_q    <= hist_d;
        end
    end
endmodule

// File: doc/seq_tx_101.md
Name: seq_tx_101

Overview:
- Serial frame transmitter. It is the sending end of the "101" sequence-detect link.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits a "101" preamble on a 1-bit line, then the payload MSB-first with zero-bit stuffing, then a run of zero guard bits.
- Stuffing guarantees that a downstream "101" detector fires only on the preamble.

Parameters:
- DATA_W, 8, payload width in bits (>=2).
- GAP_BITS, 2, zero guard bits after each frame (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  payload word; sampled only on an accepted handshake.
- data_valid  input  1  payload available.
- data_ready  output  1  block can accept a payload this cycle.
- seq_out  output  1  serial line.
- busy  output  1  frame in progress (crnt_state != IDLE).
- frame_done  output  1  high during the final guard-bit cycle.
- crnt_state  output  3  current FSM state, for debug and bench visibility.

Behaviour:
- Reset: crnt_state=IDLE, shift register=0, bit counter=0, gap counter=0, hist=2'b00.
  - All outputs at reset: seq_out=0, busy=0, frame_done=0, data_ready=1.
  - Reset mid-frame aborts immediately (async). The line drops to 0 and the frame is lost.
- States and encodings: IDLE=000, PRE1=001, PRE0=010, PRE2=011, DATA=100, STUFF=101, GAP=110. Other codes go to IDLE.
- seq_out is a combinational Moore decode of crnt_state:
  - IDLE, PRE0, STUFF, GAP output 0.
  - PRE1, PRE2 output 1.
  - DATA outputs shift register MSB.
- data_ready=1 in IDLE, and in GAP on its last cycle. Otherwise 0.
- Handshake: accept = data_valid && data_ready at a posedge.
  - On accept: load data_in, bit counter=DATA_W, next state PRE1.
  - Accept in the last GAP cycle gives back-to-back frames with no IDLE cycle.
  - data_valid without ready is ignored. The block holds no obligation for it.
- Transitions:
  - PRE1 -> PRE0 -> PRE2, one cycle each.
  - At the end of PRE2: hist=2'b01, next state DATA.
- DATA, one payload bit per cycle, bit b = shift MSB:
  - hist <= {hist[0], b}; shift left by 1; bit counter decrements.
  - If the counter reaches 0: next state GAP, gap counter=GAP_BITS.
  - Else if the new hist==2'b10: next state STUFF.
  - Else: stay in DATA.
- STUFF: emits one 0, hist <= 2'b00, next state DATA. No stuffing is applied after the final payload bit, because GAP supplies the zeros.
- GAP: lasts GAP_BITS cycles; frame_done=1 on the last one. Next state is PRE1 if accepted, else IDLE.
- Frame length = 3 + DATA_W + (number of stuffed bits) + GAP_BITS cycles.
- Guarantee: from PRE0 until the next preamble, the line never contains 1-0-1.

Test Plan:
- Reset with data_valid held low -> seq_out=0, data_ready=1, busy=0, crnt_state=000; stays idle for 10 cycles.
- Accept 8'hFF -> line 1,0,1, then 1×8, then 0,0. This is 13 cycles, no STUFF state visited, and frame_done is high only on cycle 13.
- Accept 8'hA5 -> line 1,0,1,1,0,0,1,0,0,0,1,0,0,1,0,0. This is 16 cycles with 3 STUFF visits, and no "101" after the preamble.
- Accept 8'h55 -> line 1,0,1,0,0,1,0,0,1,0,0,1,0,0,1,0,0. This is 17 cycles with 4 STUFF visits.
- data_valid held high with 8'hFF then 8'h00 -> the second frame starts in the cycle after frame_done with no IDLE gap. Its line is 1,0,1,0,0,0×7,0,0, i.e. 1 stuff bit.
- Assert reset_n=0 mid-DATA of an 8'hA5 frame -> seq_out=0 and crnt_state=000 immediately, without waiting for a clock. After release, a new 8'hFF frame is transmitted correctly.
